// File: rtl/ext_slave_mailbox.sv
// OBI responder for the external slave port: shared mailbox RAM,
// doorbell register with level interrupt, and status register.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   slave_req_i  OBI request  {req, we, be, addr, wdata}
//   slave_resp_o OBI response {gnt, rvalid, rdata}
//   irq_o        doorbell pending (level)
//   irq_ack_i    external clear of the pending flag
//   doorbell_o   last value written to DOORBELL

package ext_slave_mailbox_pkg;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

module ext_slave_mailbox
   import ext_slave_mailbox_pkg::*;
#(
   parameter int unsigned NUM_WORDS   = 16,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter logic [31:0] OOR_RDATA   = 32'hBADC_AB1E
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  obi_req_t    slave_req_i,
   output obi_resp_t   slave_resp_o,
   output logic        irq_o,
   input  logic        irq_ack_i,
   output logic [31:0] doorbell_o
);

   localparam int unsigned AW = $clog2(NUM_WORDS);
   localparam logic [29:0] IDX_DB = 30'(NUM_WORDS);
   localparam logic [29:0] IDX_ST = 30'(NUM_WORDS + 1);
   localparam bit          NO_WAIT = (WAIT_CYCLES == 0);
   localparam logic [3:0]  CNT_LOAD =
      NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        gnt;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [31:0] mem [NUM_WORDS];

   logic        below;
   logic [29:0] idx;
   logic        hit_mem;
   logic        hit_db;
   logic        hit_st;
   logic        acc;
   logic        wr;
   logic        rd;
   logic [31:0] rd_word;

   // Decode the word index relative to the block base.
   always_comb begin
      below   = slave_req_i.addr < ADDR_BASE;
      idx     = 30'((slave_req_i.addr - ADDR_BASE) >> 2);
      hit_mem = !below && (idx < IDX_DB);
      hit_db  = !below && (idx == IDX_DB);
      hit_st  = !below && (idx == IDX_ST);
   end

   // Grant is combinational so a zero-wait block can grant in the
   // same cycle the request is seen.
   always_comb begin
      gnt = 1'b0;
      if (!rst_i) begin
         if (state == S_IDLE)
            gnt = slave_req_i.req && NO_WAIT;
         else
            gnt = slave_req_i.req && (cnt == 4'd0);
      end
   end

   assign acc = slave_req_i.req && gnt;
   assign wr  = acc && slave_req_i.we;
   assign rd  = acc && !slave_req_i.we;

   always_comb begin
      rd_word = OOR_RDATA;
      unique case (1'b1)
         hit_mem: rd_word = mem[idx[AW-1:0]];
         hit_db:  rd_word = doorbell_o;
         hit_st:  rd_word = {31'b0, irq_o};
         default: rd_word = OOR_RDATA;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (slave_req_i.req && !NO_WAIT) begin
                  state <= S_WAIT;
                  cnt   <= CNT_LOAD;
               end
            end
            S_WAIT: begin
               // A dropped request abandons the wait with no access.
               if (!slave_req_i.req || cnt == 4'd0)
                  state <= S_IDLE;
               else
                  cnt <= cnt - 4'd1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'd0;
         irq_o      <= 1'b0;
         doorbell_o <= 32'd0;
         for (int i = 0; i < NUM_WORDS; i++)
            mem[i] <= 32'd0;
      end else begin
         rvalid_q <= acc;
         rdata_q  <= rd ? rd_word : 32'd0;
         for (int b = 0; b < 4; b++) begin
            if (wr && slave_req_i.be[b]) begin
               if (hit_mem)
                  mem[idx[AW-1:0]][8*b +: 8] <=
                     slave_req_i.wdata[8*b +: 8];
               if (hit_db)
                  doorbell_o[8*b +: 8] <=
                     slave_req_i.wdata[8*b +: 8];
            end
         end
         // A doorbell write wins over any clear in the same cycle.
         if (wr && hit_db)
            irq_o <= 1'b1;
         else if ((wr && hit_st && slave_req_i.be[0] &&
                   slave_req_i.wdata[0]) || irq_ack_i)
            irq_o <= 1'b0;
      end
   end

   assign slave_resp_o = '{gnt:    gnt,
                           rvalid: rvalid_q,
                           rdata:  rdata_q};

endmodule
